// File: rtl/exe_muldiv.sv
// Execute-stage multiply/divide unit: owns HI/LO, single-cycle MULT/MULTU,
// 32-step restoring DIV/DIVU that requests a pipeline stall while it runs.
module exe_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  output logic        o_stallreq,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_qneg;
  logic        r_rneg;

  logic        w_idle;
  logic        w_signed;
  logic        w_mul_wr;
  logic        w_div_req;
  logic        w_launch;
  logic        w_step;
  logic        w_div_fin;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;

  assign w_idle    = (r_state == S_IDLE);
  assign w_signed  = ~i_op[0];
  assign w_mul_wr  = w_idle && i_start && !i_op[1] && !flush;
  assign w_div_req = w_idle && i_start && i_op[1] && !flush;
  assign w_launch  = w_div_req && (i_db != 32'd0);
  assign w_step    = (r_state == S_RUN) && !flush;
  assign w_div_fin = w_step && (r_cnt == 5'd31);

  // One 64-bit multiplier serves both ops: sign- or zero-extend, keep low half.
  assign w_ma   = w_signed ? {{32{i_da[31]}}, i_da} : {32'd0, i_da};
  assign w_mb   = w_signed ? {{32{i_db[31]}}, i_db} : {32'd0, i_db};
  assign w_prod = w_ma * w_mb;

  assign w_abs_a = (w_signed && i_da[31]) ? (32'd0 - i_da) : i_da;
  assign w_abs_b = (w_signed && i_db[31]) ? (32'd0 - i_db) : i_db;

  // Dividend bits shift out of the quotient register into the remainder.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_sub    = w_shift[31:0] - r_dvs;
  assign w_rem_nx = w_ge ? w_sub : w_shift[31:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_div_req) w_next = (i_db == 32'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == 5'd31) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_cnt  <= 5'd0;
      r_rem  <= 32'd0;
      r_quo  <= 32'd0;
      r_dvs  <= 32'd0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else begin
      if (w_mul_wr) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (w_idle && !flush) begin
        if (i_mthi) r_hi <= i_da;
        if (i_mtlo) r_lo <= i_da;
      end
      if (w_launch) begin
        r_quo  <= w_abs_a;
        r_dvs  <= w_abs_b;
        r_rem  <= 32'd0;
        r_cnt  <= 5'd0;
        r_qneg <= w_signed && (i_da[31] ^ i_db[31]);
        r_rneg <= w_signed && i_da[31];
      end else if (w_step) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_div_fin) begin
        r_lo <= r_qneg ? (32'd0 - w_quo_nx) : w_quo_nx;
        r_hi <= r_rneg ? (32'd0 - w_rem_nx) : w_rem_nx;
      end
    end
  end

  assign o_stallreq = !flush && (w_div_req || (r_state == S_RUN));
  assign o_busy     = (r_state == S_RUN);
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed corner cases plus randomized
// mult/div/mthi/mtlo traffic compared against an arithmetic reference model.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_da;
  logic [31:0] i_db;
  logic        i_mthi;
  logic        i_mtlo;
  logic        o_stallreq;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  exe_muldiv dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_da       (i_da),
    .i_db       (i_db),
    .i_mthi     (i_mthi),
    .i_mtlo     (i_mtlo),
    .o_stallreq (o_stallreq),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    logic signed [31:0] s_a;
    logic signed [31:0] s_b;
    longint             la;
    longint             lb;
    longint             q;
    longint             r;
    logic [63:0]        ua;
    logic [63:0]        ub;
    s_a = a;
    s_b = b;
    la  = s_a;
    lb  = s_b;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      2'd0: return la * lb;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {hi, lo};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic do_mult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    i_start = 1'b1; i_op = op; i_da = a; i_db = b;
    exp_q.push_back(ref_op(op, a, b, m_hi, m_lo));
    #1 check("mul_stall", {63'd0, o_stallreq}, 64'd0);
    @(negedge clk);
    i_start = 1'b0;
    e = exp_q.pop_front();
    {m_hi, m_lo} = e;
    #1 check("mul_hilo", {o_hi, o_lo}, e);
  endtask

  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          n_stall;
    int          n_busy;
    bit          ended;
    n_stall = 0; n_busy = 0; ended = 0;
    i_start = 1'b1; i_op = op; i_da = a; i_db = b;
    exp_q.push_back(ref_op(op, a, b, m_hi, m_lo));
    for (int k = 0; k < 40; k++) begin
      #1;
      if (o_busy) n_busy++;
      if (!o_stallreq) begin
        ended = 1;
        break;
      end
      n_stall++;
      @(negedge clk);
    end
    if (!ended) check("div_timeout", 64'd1, 64'd0);
    @(negedge clk);
    i_start = 1'b0;
    e = exp_q.pop_front();
    {m_hi, m_lo} = e;
    #1;
    check("div_hilo", {o_hi, o_lo}, e);
    check("div_stall_cycles", 64'(n_stall), (b == 32'd0) ? 64'd1 : 64'd33);
    check("div_busy_cycles", 64'(n_busy), (b == 32'd0) ? 64'd0 : 64'd32);
  endtask

  task automatic do_mt(input logic hi_en, input logic lo_en, input logic [31:0] v);
    i_mthi = hi_en; i_mtlo = lo_en; i_da = v;
    @(negedge clk);
    i_mthi = 1'b0; i_mtlo = 1'b0;
    if (hi_en) m_hi = v;
    if (lo_en) m_lo = v;
    #1 check("mt_hilo", {o_hi, o_lo}, {m_hi, m_lo});
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[1]) do_div(op, a, b);
    else       do_mult(op, a, b);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          sel;
    reset = 1'b1; flush = 1'b0; i_start = 1'b0; i_op = 2'd0;
    i_da = 32'd0; i_db = 32'd0; i_mthi = 1'b0; i_mtlo = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_hilo", {o_hi, o_lo}, 64'd0);
    check("rst_stall", {63'd0, o_stallreq}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_mult(2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_known", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_mult(2'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    check("multu_known", {o_hi, o_lo}, 64'h0000_0002_FFFF_FFFA);
    do_div(2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_div(2'd3, 32'hFFFF_FFFF, 32'h10);
    check("divu_known", {o_hi, o_lo}, 64'h0000_000F_0FFF_FFFF);
    do_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {o_hi, o_lo}, 64'h0000_0000_8000_0000);

    do_mt(1'b1, 1'b0, 32'h11);
    do_mt(1'b0, 1'b1, 32'h22);
    do_div(2'd2, 32'd1234, 32'd0);
    check("div_by_zero", {o_hi, o_lo}, 64'h0000_0011_0000_0022);
    do_div(2'd3, 32'd99, 32'd0);
    do_mt(1'b1, 1'b1, 32'hA5A5_0001);

    // Flush ten cycles into a divide.
    i_start = 1'b1; i_op = 2'd2; i_da = 32'd100; i_db = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; i_start = 1'b0;
    #1 check("flush_stall", {63'd0, o_stallreq}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {63'd0, o_busy}, 64'd0);
    check("flush_stall_after", {63'd0, o_stallreq}, 64'd0);
    check("flush_hilo", {o_hi, o_lo}, {m_hi, m_lo});
    do_mult(2'd0, 32'd3, 32'd4);
    check("flush_mult", {32'd0, o_lo}, 64'd12);

    // Back-to-back divides.
    do_div(2'd2, 32'd1000, 32'hFFFF_FFFD);
    do_div(2'd3, 32'h1234_5678, 32'h0000_0123);

    // Reset five cycles into a divide.
    i_start = 1'b1; i_op = 2'd3; i_da = 32'hDEAD_BEEF; i_db = 32'd3;
    repeat (5) @(negedge clk);
    reset = 1'b1; i_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    check("rstrun_hilo", {o_hi, o_lo}, 64'd0);
    check("rstrun_busy", {63'd0, o_busy}, 64'd0);
    check("rstrun_stall", {63'd0, o_stallreq}, 64'd0);

    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      sel = $urandom_range(0, 5);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rop = sel[1:0];
      if (sel >= 4) do_mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra);
      else          do_op(rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
